// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetches 32-bit instruction words from program ROM and hands them, together
// with their PC, to the single-cycle core. An in-order prefetch queue of DEPTH
// slots hides ROM latency. A redirect from the core flushes the queue, restarts
// fetching at the new PC and discards responses still in flight for the old
// stream.
//
// Ports:
//   i_clk, i_reset_n             clock (rising edge), async active-low reset
//   i_redirect, i_redirect_pc    restart fetch at i_redirect_pc (bits [1:0] ignored)
//   o_mem_req_valid/addr         ROM read request (word-aligned byte address)
//   i_mem_req_ready              ROM accepts the request this cycle
//   i_mem_rsp_valid/data         ROM read data, returned in request order
//   o_instr_valid/o_instr/o_instr_pc  head instruction presented to the core
//   i_instr_ready                core consumes the head instruction
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_req_addr,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_data,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q;
  logic [PW-1:0]    head_q, tail_q, fill_ptr_q, next_head;
  logic [CW-1:0]    alloc_q, pending_q, drop_q;
  logic [CW-1:0]    alloc_d, pending_d, drop_d;
  logic [CW:0]      in_use;
  logic [DEPTH-1:0] filled_q;
  logic [31:0]      slot_pc_q   [DEPTH];
  logic [31:0]      slot_data_q [DEPTH];
  logic             req_fire, pop, drop_rsp, fill_en, head_load;
  logic             unused_pc_lsbs;

  assign unused_pc_lsbs = &{1'b0, i_redirect_pc[1:0]};

  // Slots that are reserved (pending or filled) plus responses still owed to
  // the old stream must fit in the queue; this also caps drop at DEPTH.
  assign in_use          = {1'b0, alloc_q} + {1'b0, drop_q};
  assign o_mem_req_valid = (state_q != S_IDLE) && (in_use < DEPTH_W);
  assign o_mem_req_addr  = (state_q == S_IDLE) ? '0 : fetch_pc_q;
  assign o_instr_valid   = filled_q[head_q];

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred; clocked blocks use '<=' only.
  always_comb begin
    req_fire  = o_mem_req_valid & i_mem_req_ready;
    pop       = o_instr_valid & i_instr_ready;
    // Responses pay off stale requests first; only then do they fill slots.
    drop_rsp  = i_mem_rsp_valid && (drop_q != '0);
    fill_en   = i_mem_rsp_valid && (drop_q == '0) && (pending_q != '0);
    alloc_d   = alloc_q + CW'(req_fire) - CW'(pop);
    pending_d = pending_q + CW'(req_fire) - CW'(fill_en);
    drop_d    = drop_q - CW'(drop_rsp);
    if (i_redirect) begin
      // Everything still owed after this cycle belongs to the dead stream,
      // including a request accepted now; a response arriving now has
      // already been netted out of pending.
      alloc_d   = '0;
      pending_d = '0;
      drop_d    = drop_q - CW'(drop_rsp) + pending_q + CW'(req_fire) - CW'(fill_en);
    end
  end

  // Slot that will be at the head after this edge, and whether it will hold
  // a filled instruction; the output registers follow it.
  always_comb begin
    next_head = pop ? head_q + PW'(1) : head_q;
    head_load = !i_redirect &&
                (filled_q[next_head] || (fill_en && (fill_ptr_q == next_head)));
  end

  // FSM: state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // FSM: next state. S_DRAIN simply mirrors a non-zero drop count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:         state_d = S_RUN;
      S_RUN, S_DRAIN: state_d = (drop_d != '0) ? S_DRAIN : S_RUN;
      default:        state_d = S_IDLE;
    endcase
  end

  // Queue control, counters and fetch PC.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_ptr_q <= '0;
      alloc_q    <= '0;
      pending_q  <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
    end else begin
      alloc_q   <= alloc_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      if (i_redirect) begin
        fetch_pc_q <= {i_redirect_pc[31:2], 2'b00};
        head_q     <= '0;
        tail_q     <= '0;
        fill_ptr_q <= '0;
        filled_q   <= '0;
      end else begin
        if (req_fire) begin
          tail_q     <= tail_q + PW'(1);
          fetch_pc_q <= fetch_pc_q + 32'd4;
        end
        // fill_ptr_q always points at an unfilled slot and head_q at a filled
        // one when popping, so these two bit updates never collide.
        if (fill_en) begin
          filled_q[fill_ptr_q] <= 1'b1;
          fill_ptr_q           <= fill_ptr_q + PW'(1);
        end
        if (pop) begin
          filled_q[head_q] <= 1'b0;
          head_q           <= head_q + PW'(1);
        end
      end
    end
  end

  // NOTE: slot storage has no reset; a slot is only read once its filled bit
  // (which is reset) says it holds data, so clearing the array buys nothing.
  always_ff @(posedge i_clk) begin
    if (req_fire && !i_redirect) slot_pc_q[tail_q]       <= fetch_pc_q;
    if (fill_en && !i_redirect)  slot_data_q[fill_ptr_q] <= i_mem_rsp_data;
  end

  // Registered head copy: holds its last value when the queue runs empty,
  // and bypasses the response word when the new head is filled this cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_instr    <= '0;
      o_instr_pc <= '0;
    end else if (head_load) begin
      o_instr_pc <= slot_pc_q[next_head];
      o_instr    <= (fill_en && (fill_ptr_q == next_head)) ? i_mem_rsp_data
                                                           : slot_data_q[next_head];
    end
  end

  // A ROM response with nothing outstanding is a protocol violation; it is
  // ignored by the logic above.
  rsp_without_request : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(i_mem_rsp_valid && (drop_q == '0) && (pending_q == '0)));

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream of the single-cycle core: fetches 32-bit instructions from program ROM and presents them, with their PC, to the core's instruction input.
- Hides variable ROM latency with an in-order prefetch queue of DEPTH slots.
- Supports redirects (taken branch or JAL) from the core by flushing the queue and discarding stale in-flight responses.

Parameters:
DEPTH, 4, prefetch queue slots; power of two, minimum 2.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
i_clk  input  1  clock, all state on rising edge.
i_reset_n  input  1  asynchronous, active-low reset.
i_redirect  input  1  core requests fetch restart at i_redirect_pc.
i_redirect_pc  input  32  new fetch address; bits [1:0] ignored and forced to 0.
o_mem_req_valid  output  1  ROM read request valid.
i_mem_req_ready  input  1  ROM accepts request this cycle.
o_mem_req_addr  output  32  ROM read byte address, word aligned.
i_mem_rsp_valid  input  1  ROM returns one read word, in request order.
i_mem_rsp_data  input  32  returned instruction word.
o_instr_valid  output  1  o_instr/o_instr_pc hold a fetched instruction.
o_instr  output  32  instruction word for the core.
o_instr_pc  output  32  address of o_instr.
i_instr_ready  input  1  core consumes the head instruction this cycle.

Behaviour:
- Reset (asynchronous, i_reset_n=0):
  - queue empty; drop counter 0; fetch_pc=RESET_PC.
  - o_mem_req_valid=0, o_instr_valid=0; o_mem_req_addr, o_instr and o_instr_pc all 0.
  - FSM enters S_IDLE. Reset mid-transaction abandons all in-flight requests; the ROM is reset by the same signal.
- FSM:
  - S_IDLE: one cycle after reset release, no requests; then S_RUN.
  - S_RUN: drop=0.
  - S_DRAIN: drop>0. Return to S_RUN when drop reaches 0.
- Request issue:
  - Condition: o_mem_req_valid=1 when state!=S_IDLE and allocated+drop<DEPTH, where allocated = slots reserved, filled or pending.
  - o_mem_req_addr=fetch_pc. Valid and address stay stable until accepted, except on redirect.
  - Acceptance (valid&ready): reserve tail slot tagged with fetch_pc, marked unfilled; fetch_pc+=4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- Response:
  - While drop>0, a response decrements drop and is discarded.
  - Otherwise it fills the oldest unfilled slot.
  - A response with no outstanding request is a protocol error; it is ignored and a simulation assertion fires.
- Output:
  - o_instr_valid=1 when the head slot is filled. o_instr/o_instr_pc come from the head slot and are stable while valid&!ready.
  - Pop on o_instr_valid&i_instr_ready. Push, fill and pop may all occur in the same cycle.
  - Zero-bubble throughput: with a 1-cycle ROM and ready held high, one instruction per cycle once the queue is primed.
  - Fetch-to-output latency: response cycle +1 (registered slot).
- Redirect (i_redirect=1, highest priority):
  - Next edge: queue cleared; fetch_pc=i_redirect_pc&~3.
  - drop += number of outstanding unfilled slots, including a request accepted in the redirect cycle.
  - A response arriving in the redirect cycle is counted against the old outstanding set; it is neither kept nor added to drop.
  - A pop in the redirect cycle is void: the core treats that instruction as not consumed.
  - o_mem_req_valid may deassert in the redirect cycle without acceptance. The first new-address request is presented the cycle after redirect.
  - Back-to-back redirects accumulate drop; drop never exceeds DEPTH, guaranteed by the issue condition.
- Full and empty:
  - allocated=DEPTH blocks requests.
  - Empty queue gives o_instr_valid=0; o_instr/o_instr_pc hold their last values.
- Widths:
  - Pointers: log2(DEPTH) bits, wrapping.
  - allocated and drop counters: log2(DEPTH)+1 bits.

Test Plan:
- Reset release, 1-cycle ROM, ready=1 -> requests at 0x0,0x4,0x8,...; o_instr_pc sequence 0x0,0x4,... one per cycle after priming; no gaps.
- ROM ready=1, response latency 3 cycles, core ready=0 -> exactly DEPTH(4) requests issued (0x0–0xC), then o_mem_req_valid=0 until first pop.
- Redirect to 0x103 while 3 requests outstanding -> next request addr 0x100; 3 responses discarded; first o_instr_pc=0x100 with the 4th returned word.
- Redirect in the same cycle as a request acceptance and a pop -> accepted request dropped (drop=outstanding+1); popped instruction re-presented? No: queue is empty after flush; o_instr_valid=0 next cycle.
- fetch_pc=0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in order.
- Assert i_reset_n=0 mid-burst with 2 outstanding -> all outputs 0 immediately; after release the first request is at RESET_PC after one S_IDLE cycle.
